// File: rtl/l2_mem_responder.sv
// Line-granular main-memory responder behind the L2: fixed-latency read/write of 128-bit lines
// with a one-cycle ready pulse. Optional bound check is enabled by defining MEM_BOUND_CHECK_EN.
module l2_mem_responder #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDRW      = 28,
    parameter int LINEW      = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [ADDRW-1:0] mem_addr,
    input  logic [LINEW-1:0] mem_wdata,
    output logic [LINEW-1:0] mem_rdata,
    output logic             mem_ready,
    output logic             err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic                  oob_q, oob_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [LINEW-1:0]      wdata_q, wdata_d;

    logic [LINEW-1:0]      mem_q [DEPTH];
    logic [LINEW-1:0]      rdata_q;
    logic                  ready_q;
    logic                  err_q;

    logic                  addr_oob_s;
    logic                  enter_resp_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic                  err_set_s;

`ifdef MEM_BOUND_CHECK_EN
    assign addr_oob_s = |mem_addr[ADDRW-1:DEPTH_LOG2];
`else
    // Upper address bits alias onto the index in this build.
    logic unused_addr_s;
    assign unused_addr_s = ^mem_addr[ADDRW-1:DEPTH_LOG2];
    assign addr_oob_s    = 1'b0;
`endif

    // State register and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            op_wr_q <= 1'b0;
            oob_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            oob_q   <= oob_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: sample only in IDLE, count down in WAIT, RESP always returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        oob_d   = oob_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    op_wr_d = mem_write;
                    oob_d   = addr_oob_s;
                    idx_d   = mem_addr[DEPTH_LOG2-1:0];
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; uses the _d copies so a LATENCY of 1 commits the request sampled this cycle.
    always_comb begin
        enter_resp_s = (state_d == S_RESP) && (state_q != S_RESP);
        if (enter_resp_s) begin
            wr_en_s   = op_wr_d && !oob_d;
            rd_en_s   = !op_wr_d;
            err_set_s = oob_d;
        end else begin
            wr_en_s   = 1'b0;
            rd_en_s   = 1'b0;
            err_set_s = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= enter_resp_s;
            if (rd_en_s) begin
                rdata_q <= oob_d ? '0 : mem_q[idx_d];
            end
            if (err_set_s) begin
                err_q <= 1'b1;
            end
        end
    end

    // Line storage, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder: stimulus pushes expected (ready cycle, rdata), a monitor pops on mem_ready.
module tb_l2_mem_responder;

    localparam int LAT = 10;

    logic         clk;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         err;

    typedef struct {
        int           cyc;
        logic [127:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_fail;
    int   cyc;

    localparam logic [127:0] DAT_D = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] DAT_A = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] DAT_B = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] DAT_C = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    localparam logic [127:0] DAT_E = 128'h0BADF00D_12345678_9ABCDEF0_FEEDFACE;
    localparam logic [127:0] DAT_F = 128'hF00DCAFE_00000400_FFFF0000_13579BDF;

    l2_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && mem_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: ready at cycle %0d, required no ready", cyc);
            end else begin
                e = sb_q.pop_front();
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL ready_cycle: got cycle %0d, required %0d", cyc, e.cyc);
                end
                n_cmp++;
                if (mem_rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL rdata: got %h, required %h", mem_rdata, e.rdata);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Issue one request, hold it until ready, then drop it. now=1 drives in the current half-cycle.
    task automatic req(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] d,
                       input logic [127:0] exp_rd, input bit now, input bit mutate);
        bit got;
        int c0;
        if (!now) @(negedge clk);
        c0 = now ? cyc + 1 : cyc;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        sb_q.push_back('{c0 + LAT, exp_rd});
        if (mutate) begin
            @(negedge clk);
            @(negedge clk);
            mem_addr  = 28'h7;
            mem_wdata = '1;
        end
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (mem_ready) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: no ready for addr %h, required a pulse", a);
        end
    endtask

    task automatic idle_bus();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", {127'd0, mem_ready}, 128'd0);
        chk("reset_rdata", mem_rdata, 128'd0);
        chk("reset_err", {127'd0, err}, 128'd0);

        req(1'b0, 1'b1, 28'h0000005, DAT_D, 128'd0, 1'b0, 1'b0); idle_bus();
        req(1'b1, 1'b0, 28'h0000005, '0, DAT_D, 1'b0, 1'b0); idle_bus();

        // Writeback then allocate: read follows in the RESP cycle's second half, must not be sampled there.
        req(1'b0, 1'b1, 28'h0000010, DAT_A, DAT_D, 1'b0, 1'b0);
        req(1'b1, 1'b0, 28'h0000020, '0, 128'd0, 1'b1, 1'b0); idle_bus();
        req(1'b1, 1'b0, 28'h0000010, '0, DAT_A, 1'b0, 1'b0); idle_bus();

        req(1'b0, 1'b1, 28'h0000003, DAT_B, DAT_A, 1'b0, 1'b1); idle_bus();
        req(1'b1, 1'b0, 28'h0000007, '0, 128'd0, 1'b0, 1'b0); idle_bus();
        req(1'b1, 1'b0, 28'h0000003, '0, DAT_B, 1'b0, 1'b0); idle_bus();

        // Reset during WAIT: no pulse, nothing committed, array and rdata cleared.
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'h0000004;
        mem_wdata = DAT_C;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle_bus();
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_rdata", mem_rdata, 128'd0);
        chk("midreset_ready", {127'd0, mem_ready}, 128'd0);
        repeat (15) @(negedge clk);
        req(1'b1, 1'b0, 28'h0000004, '0, 128'd0, 1'b0, 1'b0); idle_bus();
        req(1'b1, 1'b0, 28'h0000003, '0, 128'd0, 1'b0, 1'b0); idle_bus();

        req(1'b0, 1'b1, 28'h0000002, DAT_E, 128'd0, 1'b0, 1'b0); idle_bus();
        req(1'b1, 1'b0, 28'h0000002, '0, DAT_E, 1'b0, 1'b0); idle_bus();
        req(1'b1, 1'b1, 28'h0000009, 128'd1, DAT_E, 1'b0, 1'b0); idle_bus();
        req(1'b1, 1'b0, 28'h0000009, '0, 128'd1, 1'b0, 1'b0); idle_bus();

        req(1'b0, 1'b1, 28'h0000400, DAT_F, 128'd1, 1'b0, 1'b0); idle_bus();
`ifdef MEM_BOUND_CHECK_EN
        chk("err_after_oob", {127'd0, err}, 128'd1);
        req(1'b1, 1'b0, 28'h0000000, '0, 128'd0, 1'b0, 1'b0); idle_bus();
        req(1'b1, 1'b0, 28'h0000400, '0, 128'd0, 1'b0, 1'b0); idle_bus();
        chk("err_sticky", {127'd0, err}, 128'd1);
`else
        req(1'b1, 1'b0, 28'h0000000, '0, DAT_F, 1'b0, 1'b0); idle_bus();
        chk("err_default", {127'd0, err}, 128'd0);
`endif

        repeat (15) @(negedge clk);
        chk("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_mem_responder.md
Name: l2_mem_responder

Overview:
Line-granular main-memory responder on the backing side of the L2 cache. Accepts level-held read/write requests for 128-bit lines, waits a fixed latency, commits or fetches the line, and returns a one-cycle ready pulse. Serves as the memory endpoint for the L2 miss/writeback path in simulation and FPGA builds.

Parameters:
LATENCY, 10, cycles from request sample to mem_ready pulse; legal range 1..255.
DEPTH_LOG2, 10, log2 of stored line count; index = mem_addr[DEPTH_LOG2-1:0].
ADDRW, 28, line address width, word-address bits [29:2].
LINEW, 128, line data width, 4 x 32-bit words.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
mem_read  in  1  read request, held high by requester until it sees mem_ready
mem_write  in  1  write request, held high by requester until it sees mem_ready
mem_addr  in  ADDRW  line address
mem_wdata  in  LINEW  write line data
mem_rdata  out  LINEW  read line data, valid in the mem_ready cycle of a read
mem_ready  out  1  one-cycle completion pulse
err  out  1  sticky out-of-range flag; tied 0 unless MEM_BOUND_CHECK_EN

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high. On reset: state=IDLE, mem_ready=0, mem_rdata=0, err=0, all 2^DEPTH_LOG2 lines=0, counter=0.
- Reset mid-operation: abort. No write is committed. mem_ready stays 0.
- States: IDLE, WAIT, RESP.
- IDLE: if (mem_read | mem_write) is high in cycle C, latch op, mem_addr and mem_wdata at the end of C. Next state is WAIT with cnt=LATENCY-1, or RESP directly if LATENCY==1.
- WAIT: cnt decrements each cycle and mem_addr/mem_wdata are ignored. Transition to RESP at the edge where cnt reaches 0.
- Request/ready timing: mem_ready is high for exactly one cycle, C+LATENCY.
- On the edge entering RESP:
  - Write: array[idx] <= latched wdata.
  - Read: mem_rdata <= array[idx].
  - mem_ready <= 1.
  - The updated array is visible to any later request.
- RESP: mem_ready=1 for this single cycle. Requests present in this cycle are stale and must not be sampled. Next state is always IDLE with mem_ready=0. A request held or freshly driven in the cycle after RESP is sampled as a new request; this supports the L2 writeback-then-allocate back-to-back sequence.
- mem_rdata holds its value until the next read response. Write responses do not change mem_rdata.
- mem_read and mem_write both high in IDLE: the request is treated as a write and no read data is returned.
- Input changes during WAIT have no effect, because the latched copy is used.
- Address bits above DEPTH_LOG2 alias onto the index (default build).
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
MEM_BOUND_CHECK_EN
- Defined: if any mem_addr[ADDRW-1:DEPTH_LOG2] bit is nonzero at sample time, the request still completes with normal latency, but:
  - writes are dropped;
  - reads return mem_rdata=0;
  - err is set to 1 and held until reset.
- Undefined: upper address bits are ignored (aliasing), and err is constant 0.

Test Plan:
- Reset, then write addr=0x0000005, wdata=0xDEADBEEF_01234567_89ABCDEF_CAFEF00D, LATENCY=10, request in cycle 3 -> mem_ready high only in cycle 13; read of 0x0000005 then returns the same 128-bit value in its ready cycle.
- Back-to-back writeback then allocate: write 0x10 held until ready; the next cycle after RESP the read of 0x20 is asserted -> read sampled immediately, ready 10 cycles later, mem_rdata=0 (never written), array[0x10] updated.
- Change mem_addr and mem_wdata to 0x7/all-ones during WAIT of a write to 0x3 -> only line 0x3 is written with the original data; line 0x7 stays 0.
- Assert reset in WAIT of a write to 0x4 -> no mem_ready pulse; a later read of 0x4 returns 0.
- mem_read=mem_write=1 for addr 0x9, wdata=0x1 -> treated as a write; mem_rdata unchanged from its prior value; a subsequent read of 0x9 returns 0x1.
- Default build: write to addr 0x400 with DEPTH_LOG2=10 -> aliases to line 0x000 and a read of 0x000 returns that data. With MEM_BOUND_CHECK_EN: the same write is dropped, err=1 from the ready cycle until reset, and a read of 0x400 returns 0.
